time_display_fmt: RTL and testbench

- Registered, multi-source display formatter for the timer/stopwatch datapath; sits between the counting/memory blocks and the 7-segment decoder.
- Selects one of N_SRC second-count sources and converts it to {minutes, seconds} with a sequential restoring divide-by-60, or passes it through raw.
- Handshaked with start/busy/disp_valid. Output holds its last result between conversions.

---
 rtl/time_display_fmt.sv | 201 ++++++++++++++++++++
 tb/tb_time_display_fmt.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_display_fmt.sv
// Display formatter: picks one of N_SRC second counts and emits {min, sec} via a
// sequential divide-by-60, or the raw value. Optional macro DISP_HOURS_EN adds disp_hr.
//
// state | meaning
// IDLE  | waiting for start; source value and fmt bit latched on accept
// LOAD  | divider initialised from the latched value
// DIV   | restoring divide-by-60, one quotient bit per cycle
// DIV2  | (DISP_HOURS_EN) second divide of the minute count into hours
// DONE  | outputs registered, disp_valid pulsed
module time_display_fmt #(
    parameter int N_SRC   = 4,
    parameter int TIME_W  = 12,
    parameter int FIELD_W = 6,
    localparam int SEL_W  = $clog2(N_SRC)
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [N_SRC*TIME_W-1:0] src_time,
    input  logic [N_SRC-1:0]        src_fmt,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    start,
    output logic                    busy,
    output logic                    disp_valid,
    output logic [2*FIELD_W-1:0]    disp_out,
`ifdef DISP_HOURS_EN
    output logic [FIELD_W-1:0]      disp_hr,
`endif
    output logic                    disp_ovf
);

    localparam int N_PAD = 1 << SEL_W;
    localparam int REM_W = 7;
    localparam int CNT_W = $clog2(TIME_W + 1);
    localparam logic [REM_W-1:0]   DIVISOR   = 7'd60;
    localparam logic [TIME_W-1:0]  FIELD_MAX = TIME_W'((1 << FIELD_W) - 1);
    localparam logic [FIELD_W-1:0] SAT_MAX   = '1;
    localparam logic [FIELD_W-1:0] SEC_SAT   = FIELD_W'(59);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_DIV  = 3'd2,
`ifdef DISP_HOURS_EN
        S_DIV2 = 3'd3,
`endif
        S_DONE = 3'd4
    } state_t;

    state_t state, state_nxt;

    // Unpopulated select codes read as value 0, fmt 0.
    logic [N_PAD-1:0][TIME_W-1:0] src_arr;
    logic [N_PAD-1:0]             fmt_arr;

    for (genvar g = 0; g < N_PAD; g++) begin : g_src
        if (g < N_SRC) begin : g_real
            assign src_arr[g] = src_time[g*TIME_W +: TIME_W];
            assign fmt_arr[g] = src_fmt[g];
        end else begin : g_pad
            assign src_arr[g] = '0;
            assign fmt_arr[g] = 1'b0;
        end
    end

    logic [TIME_W-1:0] val_r;
    logic              fmt_r;
    logic [TIME_W-1:0] dvd;
    logic [REM_W-1:0]  rem;
    logic [CNT_W-1:0]  cnt;
`ifdef DISP_HOURS_EN
    logic [FIELD_W-1:0] sec_r;
`endif

    logic              accept, load_div, div_step, div_last, div1_last, finish;
    logic [REM_W-1:0]  rem_sh, rem_nxt;
    logic              sub_ok;
    logic [TIME_W-1:0] quo_nxt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: state_nxt = fmt_r ? S_DIV : S_DONE;
`ifdef DISP_HOURS_EN
            S_DIV:  if (div_last) state_nxt = S_DIV2;
            S_DIV2: if (div_last) state_nxt = S_DONE;
`else
            S_DIV:  if (div_last) state_nxt = S_DONE;
`endif
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        accept    = 1'b0;
        load_div  = 1'b0;
        div_step  = 1'b0;
        div1_last = 1'b0;
        finish    = 1'b0;
        div_last  = (cnt == CNT_W'(1));
        case (state)
            S_IDLE: accept = start;
            S_LOAD: load_div = 1'b1;
            S_DIV: begin
                div_step  = 1'b1;
                div1_last = div_last;
            end
`ifdef DISP_HOURS_EN
            S_DIV2: div_step = 1'b1;
`endif
            S_DONE: finish = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

    // Quotient bits shift into the dividend register as its MSBs shift out.
    assign rem_sh  = {rem[REM_W-2:0], dvd[TIME_W-1]};
    assign sub_ok  = (rem_sh >= DIVISOR);
    assign rem_nxt = sub_ok ? (rem_sh - DIVISOR) : rem_sh;
    assign quo_nxt = {dvd[TIME_W-2:0], sub_ok};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            val_r      <= '0;
            fmt_r      <= 1'b0;
            dvd        <= '0;
            rem        <= '0;
            cnt        <= '0;
            disp_valid <= 1'b0;
            disp_out   <= '0;
            disp_ovf   <= 1'b0;
`ifdef DISP_HOURS_EN
            sec_r      <= '0;
            disp_hr    <= '0;
`endif
        end else begin
            if (accept) begin
                val_r <= src_arr[sel];
                fmt_r <= fmt_arr[sel];
            end

            if (load_div) begin
                dvd <= val_r;
                rem <= '0;
                cnt <= CNT_W'(TIME_W);
            end else if (div_step) begin
                dvd <= quo_nxt;
                rem <= rem_nxt;
                cnt <= cnt - CNT_W'(1);
`ifdef DISP_HOURS_EN
                // Seconds are final after the first pass; restart on the minute count.
                if (div1_last) begin
                    sec_r <= FIELD_W'(rem_nxt);
                    rem   <= '0;
                    cnt   <= CNT_W'(TIME_W);
                end
`endif
            end

            disp_valid <= finish;

            if (finish) begin
                if (!fmt_r) begin
                    disp_out <= (2*FIELD_W)'(val_r);
                    disp_ovf <= 1'b0;
`ifdef DISP_HOURS_EN
                    disp_hr  <= '0;
`endif
                end else if (dvd > FIELD_MAX) begin
                    disp_ovf <= 1'b1;
`ifdef DISP_HOURS_EN
                    disp_hr  <= SAT_MAX;
                    disp_out <= {SEC_SAT, SEC_SAT};
`else
                    disp_out <= {SAT_MAX, SEC_SAT};
`endif
                end else begin
                    disp_ovf <= 1'b0;
`ifdef DISP_HOURS_EN
                    disp_hr  <= FIELD_W'(dvd);
                    disp_out <= {FIELD_W'(rem), sec_r};
`else
                    disp_out <= {FIELD_W'(dvd), FIELD_W'(rem)};
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_time_display_fmt.sv
// Self-checking bench for time_display_fmt: directed cases plus random conversions
// checked against an arithmetic div/mod model.
module tb_time_display_fmt;

    localparam int N_SRC   = 4;
    localparam int TIME_W  = 12;
    localparam int FIELD_W = 6;
    localparam int SEL_W   = 2;
    localparam int RAW_LAT = 2;
`ifdef DISP_HOURS_EN
    localparam int CONV_LAT = 2*TIME_W + 2;
`else
    localparam int CONV_LAT = TIME_W + 2;
`endif

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic [N_SRC*TIME_W-1:0] src_time;
    logic [N_SRC-1:0]        src_fmt;
    logic [SEL_W-1:0]        sel;
    logic                    start;
    logic                    busy, disp_valid, disp_ovf;
    logic [2*FIELD_W-1:0]    disp_out;

    logic [3*TIME_W-1:0]     src_time3;
    logic [2:0]              src_fmt3;
    logic [1:0]              sel3;
    logic                    start3;
    logic                    busy3, valid3, ovf3;
    logic [2*FIELD_W-1:0]    out3;
`ifdef DISP_HOURS_EN
    logic [FIELD_W-1:0]      disp_hr, hr3;
`endif

    time_display_fmt #(.N_SRC(N_SRC), .TIME_W(TIME_W), .FIELD_W(FIELD_W)) dut (
        .clk(clk), .nrst(nrst), .src_time(src_time), .src_fmt(src_fmt), .sel(sel),
        .start(start), .busy(busy), .disp_valid(disp_valid), .disp_out(disp_out),
`ifdef DISP_HOURS_EN
        .disp_hr(disp_hr),
`endif
        .disp_ovf(disp_ovf)
    );

    time_display_fmt #(.N_SRC(3), .TIME_W(TIME_W), .FIELD_W(FIELD_W)) dut3 (
        .clk(clk), .nrst(nrst), .src_time(src_time3), .src_fmt(src_fmt3), .sel(sel3),
        .start(start3), .busy(busy3), .disp_valid(valid3), .disp_out(out3),
`ifdef DISP_HOURS_EN
        .disp_hr(hr3),
`endif
        .disp_ovf(ovf3)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input int v, input bit f);
        src_time[i*TIME_W +: TIME_W] = TIME_W'(v);
        src_fmt[i] = f;
    endtask

    // Reference: plain div/mod on seconds, saturating the top field.
    task automatic model(input int v, input bit f, output logic [2*FIELD_W-1:0] o,
                         output logic ovf, output logic [FIELD_W-1:0] hr);
        int maxf, h, m, s;
        maxf = (1 << FIELD_W) - 1;
        hr   = '0;
        ovf  = 1'b0;
        h    = 0;
        if (!f) begin
            o = (2*FIELD_W)'(v);
        end else begin
            s = v % 60;
`ifdef DISP_HOURS_EN
            h = v / 3600;
            m = (v / 60) % 60;
            if (h > maxf) begin
                h = maxf; m = 59; s = 59; ovf = 1'b1;
            end
`else
            m = v / 60;
            if (m > maxf) begin
                m = maxf; s = 59; ovf = 1'b1;
            end
`endif
            hr = FIELD_W'(h);
            o  = {FIELD_W'(m), FIELD_W'(s)};
        end
    endtask

    task automatic wait_valid(output int cyc, output bit busy_ok);
        cyc = 0;
        busy_ok = 1'b1;
        while (disp_valid !== 1'b1 && cyc < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_conv(input int s, input string tag, input bit scramble);
        logic [2*FIELD_W-1:0] eo;
        logic                 eovf;
        logic [FIELD_W-1:0]   ehr;
        int cyc, v;
        bit bok, f;
        v = int'(src_time[s*TIME_W +: TIME_W]);
        f = src_fmt[s];
        model(v, f, eo, eovf, ehr);
        sel = SEL_W'(s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (scramble) begin
            for (int i = 0; i < N_SRC; i++) set_src(i, $urandom_range(0, 4095), 1'($urandom));
            sel = SEL_W'($urandom);
        end
        wait_valid(cyc, bok);
        chk($sformatf("%s_latency", tag), 32'(cyc), 32'(f ? CONV_LAT : RAW_LAT));
        chk($sformatf("%s_busy_held", tag), 32'(bok), 32'd1);
        chk($sformatf("%s_busy_clr", tag), 32'(busy), 32'd0);
        chk($sformatf("%s_out", tag), 32'(disp_out), 32'(eo));
        chk($sformatf("%s_ovf", tag), 32'(disp_ovf), 32'(eovf));
`ifdef DISP_HOURS_EN
        chk($sformatf("%s_hr", tag), 32'(disp_hr), 32'(ehr));
`endif
        @(posedge clk); #1;
        chk($sformatf("%s_pulse", tag), 32'(disp_valid), 32'd0);
    endtask

    task automatic run3(input int s, input string tag, input logic [2*FIELD_W-1:0] eo,
                        input logic eovf);
        int cyc;
        sel3 = 2'(s);
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        cyc = 0;
        while (valid3 !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("%s_latency", tag), 32'(cyc), 32'(RAW_LAT));
        chk($sformatf("%s_out", tag), 32'(out3), 32'(eo));
        chk($sformatf("%s_ovf", tag), 32'(ovf3), 32'(eovf));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, nvalid, v;
        bit bok;
        logic [2*FIELD_W-1:0] cap_out, eo;
        logic eovf;
        logic [FIELD_W-1:0] ehr;
        int edges [6] = '{0, 59, 60, 3599, 3600, 4095};

        src_time = '0; src_fmt = '0; sel = '0; start = 1'b0;
        src_time3 = '0; src_fmt3 = '0; sel3 = '0; start3 = 1'b0;
        cap_out = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(disp_valid), 32'd0);
        chk("rst_out", 32'(disp_out), 32'd0);
        chk("rst_ovf", 32'(disp_ovf), 32'd0);
        nrst = 1'b1;
        @(posedge clk); #1;

        set_src(2, 125, 1'b1);      run_conv(2, "s2_125", 1'b0);
        set_src(0, 4095, 1'b1);     run_conv(0, "s0_4095", 1'b0);
        set_src(3, 'hABC, 1'b0);    run_conv(3, "raw_abc", 1'b0);
        set_src(1, 59, 1'b1);       run_conv(1, "b59", 1'b0);
        set_src(1, 60, 1'b1);       run_conv(1, "b60", 1'b0);
        set_src(1, 0, 1'b1);        run_conv(1, "b0", 1'b0);

        // Mid-flight source change and extra start must not disturb the conversion.
        set_src(2, 125, 1'b1);
        sel = 2'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nvalid = 0;
        for (int c = 1; c <= CONV_LAT + 6; c++) begin
            if (c == 3) begin set_src(2, 0, 1'b0); sel = 2'd0; start = 1'b1; end
            if (c == 5) start = 1'b0;
            @(posedge clk); #1;
            if (disp_valid === 1'b1) begin nvalid++; cap_out = disp_out; end
        end
        chk("inflight_nvalid", 32'(nvalid), 32'd1);
        chk("inflight_out", 32'(cap_out), 32'({6'd2, 6'd5}));
        chk("inflight_idle", 32'(busy), 32'd0);

        // Held start: back-to-back with one IDLE cycle between conversions.
        set_src(1, 200, 1'b1);
        sel = 2'd1; start = 1'b1;
        wait_valid(cyc, bok);
        chk("b2b_first_lat", 32'(cyc), 32'(CONV_LAT + 1));
        @(posedge clk); #1;
        chk("b2b_idle_gap", 32'(disp_valid), 32'd0);
        wait_valid(cyc, bok);
        start = 1'b0;
        chk("b2b_second_lat", 32'(cyc), 32'(CONV_LAT));
        chk("b2b_busy_held", 32'(bok), 32'd1);
        chk("b2b_out", 32'(disp_out), 32'({6'd3, 6'd20}));
        @(posedge clk); #1;
        chk("b2b_no_third", 32'(busy), 32'd0);

        // Asynchronous reset during DIV.
        set_src(2, 125, 1'b1);
        sel = 2'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        chk("arst_out", 32'(disp_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(disp_valid), 32'd0);
        chk("arst_ovf", 32'(disp_ovf), 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        nvalid = 0;
        for (int c = 0; c < CONV_LAT + 4; c++) begin
            @(posedge clk); #1;
            if (disp_valid === 1'b1) nvalid++;
        end
        chk("arst_no_valid", 32'(nvalid), 32'd0);
        run_conv(2, "post_rst", 1'b0);

        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < N_SRC; k++) begin
                v = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)]
                                                : int'($urandom_range(0, 4095));
                set_src(k, v, 1'($urandom));
            end
            run_conv($urandom_range(0, N_SRC - 1), $sformatf("rnd%0d", i), 1'b1);
        end

        // Three-source instance: out-of-range select reads as raw zero.
        src_time3 = {12'd4095, 12'd77, 12'd900};
        src_fmt3  = 3'b100;
        run3(1, "n3_raw", 12'd77, 1'b0);
        src_fmt3  = 3'b000;
        src_time3[2*TIME_W +: TIME_W] = 12'hFED;
        run3(2, "n3_raw2", 12'hFED, 1'b0);
        run3(3, "n3_sel3", 12'd0, 1'b0);

        model(4095, 1'b1, eo, eovf, ehr);
        set_src(0, 4095, 1'b1);
        run_conv(0, "s0_4095_again", 1'b0);
        chk("s0_4095_model_ovf", 32'(disp_ovf), 32'(eovf));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
